// File: rtl/vm2002_common_pkg.sv
// Shared vm2002 types: change-coin encoding, coin values and the change-dispenser state.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } change_coin_t;

  localparam logic [15:0] NICKEL_CENTS  = 16'd5;
  localparam logic [15:0] DIME_CENTS    = 16'd10;
  localparam logic [15:0] QUARTER_CENTS = 16'd25;

  typedef enum logic [2:0] {
    CHG_IDLE,
    CHG_SELECT,
    CHG_EJECT,
    CHG_DONE,
    CHG_FAULT
  } chg_state_t;

  function automatic logic [15:0] coin_cents(input change_coin_t c);
    case (c)
      COIN_NICKEL:  coin_cents = NICKEL_CENTS;
      COIN_DIME:    coin_cents = DIME_CENTS;
      COIN_QUARTER: coin_cents = QUARTER_CENTS;
      default:      coin_cents = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// One coin-tube inventory counter: adds restocks, removes one coin per eject,
// and saturates at the all-ones count.
module vm2002_coin_tube #(
  parameter int TUBE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [TUBE_W-1:0] i_load_count,
  input  logic              i_dec,
  output logic [TUBE_W-1:0] o_cnt
);

  logic [TUBE_W-1:0] r_cnt;
  logic [TUBE_W:0]   w_sum;
  logic [TUBE_W:0]   w_next;

  function automatic logic [TUBE_W-1:0] sat_cnt(input logic [TUBE_W:0] v);
    if (v[TUBE_W])
      sat_cnt = {TUBE_W{1'b1}};
    else
      sat_cnt = v[TUBE_W-1:0];
  endfunction

  // The extra bit holds cnt + load before the decrement, so load and eject on
  // the same cycle saturate as sat(cnt + load - 1).
  always_comb begin
    w_sum  = {1'b0, r_cnt} + (i_load ? {1'b0, i_load_count} : '0);
    w_next = w_sum;
    if (i_dec && (w_sum != '0))
      w_next = w_sum - (TUBE_W + 1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else
      r_cnt <= sat_cnt(w_next);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vm2002_change_dispenser.sv
// vm2002 change-return controller: greedy Q/D/N hopper sequencing plus tube inventory.
// Optional hopper ack timeout and FAULT state: define VM2002_CHANGE_TIMEOUT_EN.
module vm2002_change_dispenser
  import vm2002_common_pkg::*;
#(
  parameter int TUBE_W      = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              hrst,
  input  logic              start,
  input  logic [15:0]       amount,
  input  logic              load_valid,
  input  logic [1:0]        load_coin,
  input  logic [TUBE_W-1:0] load_count,
  input  logic              eject_ack,
  input  logic              clr_fault,
  output logic              busy,
  output logic              eject_valid,
  output logic [1:0]        eject_coin,
  output logic              done,
  output logic              short_change,
  output logic [15:0]       residual,
  output logic              fault,
  output logic [TUBE_W-1:0] nickel_cnt,
  output logic [TUBE_W-1:0] dime_cnt,
  output logic [TUBE_W-1:0] quarter_cnt
);

  chg_state_t   r_state;
  chg_state_t   w_state_nxt;
  change_coin_t r_coin;
  change_coin_t w_sel_coin;
  logic [15:0]  r_remaining;
  logic [15:0]  r_residual;
  logic         r_short;
  logic         w_ack;
  logic         w_timeout;
  logic         w_dec_n, w_dec_d, w_dec_q;
  logic         w_ld_n, w_ld_d, w_ld_q;

  assign w_ack   = (r_state == CHG_EJECT) && eject_ack;
  assign w_dec_n = w_ack && (r_coin == COIN_NICKEL);
  assign w_dec_d = w_ack && (r_coin == COIN_DIME);
  assign w_dec_q = w_ack && (r_coin == COIN_QUARTER);
  assign w_ld_n  = load_valid && (load_coin == COIN_NICKEL);
  assign w_ld_d  = load_valid && (load_coin == COIN_DIME);
  assign w_ld_q  = load_valid && (load_coin == COIN_QUARTER);

  vm2002_coin_tube #(.TUBE_W(TUBE_W)) u_tube_nickel (
    .i_clk(clk), .i_rst(hrst), .i_load(w_ld_n), .i_load_count(load_count),
    .i_dec(w_dec_n), .o_cnt(nickel_cnt)
  );

  vm2002_coin_tube #(.TUBE_W(TUBE_W)) u_tube_dime (
    .i_clk(clk), .i_rst(hrst), .i_load(w_ld_d), .i_load_count(load_count),
    .i_dec(w_dec_d), .o_cnt(dime_cnt)
  );

  vm2002_coin_tube #(.TUBE_W(TUBE_W)) u_tube_quarter (
    .i_clk(clk), .i_rst(hrst), .i_load(w_ld_q), .i_load_count(load_count),
    .i_dec(w_dec_q), .o_cnt(quarter_cnt)
  );

  // Greedy choice against live tube counts, so a restock mid-refund counts on the next coin.
  always_comb begin
    w_sel_coin = COIN_NONE;
    if ((r_remaining >= QUARTER_CENTS) && (quarter_cnt != '0))
      w_sel_coin = COIN_QUARTER;
    else if ((r_remaining >= DIME_CENTS) && (dime_cnt != '0))
      w_sel_coin = COIN_DIME;
    else if ((r_remaining >= NICKEL_CENTS) && (nickel_cnt != '0))
      w_sel_coin = COIN_NICKEL;
  end

`ifdef VM2002_CHANGE_TIMEOUT_EN
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [TMR_W-1:0] r_timer;
  logic             r_flt_done;

  assign w_timeout = (r_state == CHG_EJECT) && !eject_ack && (r_timer == '0);

  // Loaded while in SELECT so EJECT starts with ACK_TIMEOUT-1 and faults after ACK_TIMEOUT cycles.
  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      r_timer    <= '0;
      r_flt_done <= 1'b0;
    end else begin
      r_flt_done <= w_timeout;
      if (r_state == CHG_SELECT)
        r_timer <= TMR_W'(ACK_TIMEOUT - 1);
      else if ((r_state == CHG_EJECT) && (r_timer != '0))
        r_timer <= r_timer - TMR_W'(1);
    end
  end

  assign fault = (r_state == CHG_FAULT);
  assign done  = (r_state == CHG_DONE) || r_flt_done;
`else
  logic w_unused;

  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
  assign done      = (r_state == CHG_DONE);
  assign w_unused  = clr_fault ^ (ACK_TIMEOUT == 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CHG_IDLE:   if (start) w_state_nxt = CHG_SELECT;
      CHG_SELECT: w_state_nxt = (w_sel_coin == COIN_NONE) ? CHG_DONE : CHG_EJECT;
      CHG_EJECT: begin
        if (eject_ack)
          w_state_nxt = CHG_SELECT;
        else if (w_timeout)
          w_state_nxt = CHG_FAULT;
      end
      CHG_DONE:   w_state_nxt = CHG_IDLE;
`ifdef VM2002_CHANGE_TIMEOUT_EN
      CHG_FAULT:  if (clr_fault) w_state_nxt = CHG_IDLE;
`endif
      default:    w_state_nxt = CHG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst)
      r_state <= CHG_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      r_coin      <= COIN_NONE;
      r_remaining <= '0;
      r_residual  <= '0;
      r_short     <= 1'b0;
    end else begin
      case (r_state)
        CHG_IDLE: begin
          if (start) begin
            r_remaining <= amount;
            r_residual  <= '0;
            r_short     <= 1'b0;
          end
        end
        CHG_SELECT: begin
          r_coin <= w_sel_coin;
          if (w_sel_coin == COIN_NONE) begin
            r_residual <= r_remaining;
            r_short    <= (r_remaining != '0);
          end
        end
        CHG_EJECT: begin
          if (eject_ack) begin
            r_remaining <= r_remaining - coin_cents(r_coin);
          end else if (w_timeout) begin
            r_residual <= r_remaining;
            r_short    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != CHG_IDLE);
  assign eject_valid  = (r_state == CHG_EJECT);
  assign eject_coin   = r_coin;
  assign residual     = r_residual;
  assign short_change = r_short;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Directed bench for vm2002_change_dispenser; the timeout scenario is built only
// when VM2002_CHANGE_TIMEOUT_EN is defined.
module tb_vm2002_change_dispenser;

  localparam int TUBE_W = 8;

  logic              clk = 1'b0;
  logic              hrst;
  logic              start;
  logic [15:0]       amount;
  logic              load_valid;
  logic [1:0]        load_coin;
  logic [TUBE_W-1:0] load_count;
  logic              eject_ack;
  logic              clr_fault;
  logic              busy;
  logic              eject_valid;
  logic [1:0]        eject_coin;
  logic              done;
  logic              short_change;
  logic [15:0]       residual;
  logic              fault;
  logic [TUBE_W-1:0] nickel_cnt;
  logic [TUBE_W-1:0] dime_cnt;
  logic [TUBE_W-1:0] quarter_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  vm2002_change_dispenser #(.TUBE_W(TUBE_W), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .hrst(hrst), .start(start), .amount(amount),
    .load_valid(load_valid), .load_coin(load_coin), .load_count(load_count),
    .eject_ack(eject_ack), .clr_fault(clr_fault), .busy(busy),
    .eject_valid(eject_valid), .eject_coin(eject_coin), .done(done),
    .short_change(short_change), .residual(residual), .fault(fault),
    .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .quarter_cnt(quarter_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    hrst = 1'b1;
    tick();
    tick();
    hrst = 1'b0;
    tick();
  endtask

  task automatic load(input logic [1:0] c, input logic [TUBE_W-1:0] n);
    load_valid = 1'b1;
    load_coin  = c;
    load_count = n;
    tick();
    load_valid = 1'b0;
    load_coin  = 2'b00;
    load_count = '0;
  endtask

  task automatic check_tubes(input string tag, input int q, input int d, input int n);
    check_eq({tag, ".q"}, 32'(quarter_cnt), q);
    check_eq({tag, ".d"}, 32'(dime_cnt), d);
    check_eq({tag, ".n"}, 32'(nickel_cnt), n);
  endtask

  // Runs one refund, acking each coin one cycle after it is requested.
  // exp_coins holds the expected coin sequence, coin 0 in bits [1:0].
  task automatic dispense(input string tag, input logic [15:0] amt,
                          input logic [15:0] exp_coins, input int exp_n,
                          input logic [15:0] exp_res, input int dime_ld_ack,
                          input bit restart);
    logic [1:0] got[$];
    bit waited   = 1'b0;
    bit fin      = 1'b0;
    int cyc      = 0;
    int last_ack = -100;
    int first_ev = -1;
    int nack     = 0;
    start  = 1'b1;
    amount = amt;
    tick();
    start  = 1'b0;
    amount = '0;
    while (!fin && cyc < 300) begin
      cyc++;
      eject_ack  = 1'b0;
      load_valid = 1'b0;
      load_coin  = 2'b00;
      load_count = '0;
      start      = 1'b0;
      if (restart && cyc == 1) begin
        check_eq({tag, ".busy_after_start"}, 32'(busy), 1);
        start  = 1'b1;
        amount = 16'd50;
      end
      if (done) begin
        fin = 1'b1;
        check_eq({tag, ".residual"}, 32'(residual), 32'(exp_res));
        check_eq({tag, ".short"}, 32'(short_change), 32'(exp_res != 0));
        if (nack > 0) check_eq({tag, ".ack_to_done"}, cyc - last_ack, 2);
      end else if (eject_valid) begin
        if (first_ev < 0) first_ev = cyc;
        if (waited) begin
          got.push_back(eject_coin);
          eject_ack = 1'b1;
          last_ack  = cyc;
          if (nack == dime_ld_ack) begin
            load_valid = 1'b1;
            load_coin  = 2'b10;
            load_count = 8'd5;
          end
          nack++;
          waited = 1'b0;
        end else begin
          waited = 1'b1;
        end
      end
      if (!fin) tick();
    end
    if (!fin) check_eq({tag, ".done_timeout"}, 0, 1);
    if (exp_n > 0) check_eq({tag, ".start_to_eject"}, first_ev, 2);
    check_eq({tag, ".ncoins"}, got.size(), exp_n);
    for (int i = 0; i < got.size() && i < exp_n; i++)
      check_eq($sformatf("%s.coin%0d", tag, i), 32'(got[i]), 32'(exp_coins[2*i +: 2]));
    start  = 1'b0;
    amount = '0;
    tick();
    check_eq({tag, ".busy_after_done"}, 32'(busy), 0);
    check_eq({tag, ".done_one_cycle"}, 32'(done), 0);
    check_eq({tag, ".residual_held"}, 32'(residual), 32'(exp_res));
  endtask

  initial begin
    hrst       = 1'b1;
    start      = 1'b0;
    amount     = '0;
    load_valid = 1'b0;
    load_coin  = 2'b00;
    load_count = '0;
    eject_ack  = 1'b0;
    clr_fault  = 1'b0;
    tick();
    check_eq("rst.busy", 32'(busy), 0);
    check_eq("rst.eject_valid", 32'(eject_valid), 0);
    check_eq("rst.eject_coin", 32'(eject_coin), 0);
    check_eq("rst.done", 32'(done), 0);
    check_eq("rst.short", 32'(short_change), 0);
    check_eq("rst.residual", 32'(residual), 0);
    check_eq("rst.fault", 32'(fault), 0);
    check_tubes("rst", 0, 0, 0);
    do_reset();

    // 4Q/4D/4N, 40c -> Q, D, N
    load(2'b11, 8'd4);
    load(2'b10, 8'd4);
    load(2'b01, 8'd4);
    check_tubes("load444", 4, 4, 4);
    dispense("t40", 16'd40, 16'h001B, 3, 16'd0, -1, 1'b0);
    check_tubes("t40.end", 3, 3, 3);

    // ack outside EJECT and a restock of coin 00 both leave tubes alone
    eject_ack = 1'b1;
    tick();
    eject_ack = 1'b0;
    load(2'b00, 8'd5);
    tick();
    check_tubes("idle_ack_ld00", 3, 3, 3);

    // no quarters, 2D/10N, 50c -> D, D, N x6
    do_reset();
    load(2'b10, 8'd2);
    load(2'b01, 8'd10);
    dispense("t50", 16'd50, 16'h555A, 8, 16'd0, -1, 1'b0);
    check_tubes("t50.end", 0, 0, 4);

    // 1Q only, 37c -> Q, residual 12
    do_reset();
    load(2'b11, 8'd1);
    dispense("t37", 16'd37, 16'h0003, 1, 16'd12, -1, 1'b0);
    check_tubes("t37.end", 0, 0, 0);

    // dime restock of 5 on the dime ack cycle, from 2 dimes -> 6
    do_reset();
    load(2'b10, 8'd2);
    dispense("tld", 16'd10, 16'h0002, 1, 16'd0, 0, 1'b0);
    check_eq("tld.dime", 32'(dime_cnt), 6);

    // zero amount and a sub-nickel amount
    dispense("t0", 16'd0, 16'h0000, 0, 16'd0, -1, 1'b0);
    load(2'b01, 8'd1);
    dispense("t3", 16'd3, 16'h0000, 0, 16'd3, -1, 1'b0);
    check_eq("t3.nickel", 32'(nickel_cnt), 1);

    // saturation: 250 + 10 -> 255
    load(2'b01, 8'd249);
    load(2'b01, 8'd10);
    check_eq("sat.nickel", 32'(nickel_cnt), 255);

    // a second start while busy is ignored
    do_reset();
    load(2'b11, 8'd2);
    dispense("tbusy", 16'd25, 16'h0003, 1, 16'd0, -1, 1'b1);
    check_eq("tbusy.quarter", 32'(quarter_cnt), 1);

    // asynchronous reset during EJECT
    start  = 1'b1;
    amount = 16'd25;
    tick();
    start  = 1'b0;
    tick();
    tick();
    check_eq("hrst.pre_eject", 32'(eject_valid), 1);
    #2 hrst = 1'b1;
    #1;
    check_eq("hrst.eject_valid", 32'(eject_valid), 0);
    check_eq("hrst.busy", 32'(busy), 0);
    check_eq("hrst.done", 32'(done), 0);
    check_eq("hrst.quarter", 32'(quarter_cnt), 0);
    tick();
    hrst = 1'b0;
    tick();
    load(2'b11, 8'd1);
    dispense("post_rst", 16'd25, 16'h0003, 1, 16'd0, -1, 1'b0);

`ifdef VM2002_CHANGE_TIMEOUT_EN
    begin
      int ev_cycles = 0;
      bit flt = 1'b0;
      do_reset();
      load(2'b11, 8'd1);
      start  = 1'b1;
      amount = 16'd30;
      tick();
      start  = 1'b0;
      for (int i = 0; i < 40 && !flt; i++) begin
        if (fault) begin
          flt = 1'b1;
          check_eq("to.done", 32'(done), 1);
          check_eq("to.eject_valid", 32'(eject_valid), 0);
          check_eq("to.residual", 32'(residual), 30);
          check_eq("to.short", 32'(short_change), 1);
        end else begin
          if (eject_valid) ev_cycles++;
          tick();
        end
      end
      check_eq("to.fault_seen", 32'(flt), 1);
      check_eq("to.eject_cycles", ev_cycles, 8);
      start  = 1'b1;
      amount = 16'd5;
      tick();
      start  = 1'b0;
      check_eq("to.done_pulse", 32'(done), 0);
      check_eq("to.fault_held", 32'(fault), 1);
      check_eq("to.start_ignored", 32'(eject_valid), 0);
      clr_fault = 1'b1;
      tick();
      clr_fault = 1'b0;
      check_eq("to.clr_fault", 32'(fault), 0);
      check_eq("to.clr_busy", 32'(busy), 0);
      check_eq("to.quarter", 32'(quarter_cnt), 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vm2002_change_dispenser.md
# vm2002_change_dispenser

Change-return controller for the vm2002 vending machine. It accepts a refund amount in cents from the main FSM once an item is dispensed or a purchase is aborted. It sequences the coin hopper one coin at a time using greedy quarter/dime/nickel selection, and owns the three coin-tube inventory counters. It sits between the vm2002 FSM and the external hopper, and reports completion, any unpaid remainder, and hopper faults.

## Interface
Parameters:
- TUBE_W, 8: width of each coin-tube counter; counters saturate at 2^TUBE_W-1.
- ACK_TIMEOUT, 64: cycles to wait for `eject_ack` before faulting. Used only with the timeout feature.

Ports:
- clk  in  1  single clock, rising edge.
- hrst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to return `amount`. Accepted only while `busy`=0.
- amount  in  16  refund in cents (0.01 units), sampled with `start`.
- load_valid  in  1  restock a tube this cycle.
- load_coin  in  2  tube to restock.
- load_count  in  TUBE_W  coins added to the tube.
- eject_ack  in  1  hopper has released the requested coin.
- clr_fault  in  1  clears the FAULT state.
- busy  out  1  request in progress (any state other than IDLE).
- eject_valid  out  1  coin request to hopper.
- eject_coin  out  2  coin requested. Encoding: 00 none, 01 NICKEL, 10 DIME, 11 QUARTER.
- done  out  1  one-cycle completion pulse.
- short_change  out  1  valid with `done`; `residual` is non-zero.
- residual  out  16  cents not returned, held until the next `start`.
- fault  out  1  hopper timeout fault, held until cleared.
- nickel_cnt, dime_cnt, quarter_cnt  out  TUBE_W each  tube inventory.

Reset: every output is 0, all counters are 0, and the state is IDLE.

## Operation
- States: IDLE, SELECT, EJECT, DONE, FAULT.
- IDLE:
  - `start` loads `remaining`=`amount`, clears `residual` and `short_change`, and moves to SELECT.
  - `start` while `busy` is ignored.
- SELECT chooses the first rule that matches, in this order:
  - `remaining`>=25 and `quarter_cnt`>0: QUARTER.
  - else `remaining`>=10 and `dime_cnt`>0: DIME.
  - else `remaining`>=5 and `nickel_cnt`>0: NICKEL.
  - else go to DONE.
  - Selection is registered into `eject_coin`, then the FSM moves to EJECT.
- EJECT:
  - `eject_valid`=1 and `eject_coin` are held stable until `eject_ack`.
  - On ack: the selected tube decrements, `remaining` drops by the coin value, and the FSM returns to SELECT.
  - `eject_valid` deasserts on the cycle after the ack.
- DONE:
  - `done`=1 for one cycle.
  - `residual`=`remaining`; `short_change`=(`remaining`!=0).
  - Next state is IDLE.
- `amount`=0: SELECT goes straight to DONE with `short_change`=0.
- Amounts that are not multiples of 5 end with `residual` = amount mod 5 or more, and `short_change`=1.
- Restock:
  - A restock adds `load_count` to the tube named by `load_coin`, saturating at the maximum count.
  - `load_coin`=00 is ignored.
  - Restock is allowed in any state.
- Simultaneous restock and decrement on the same tube give result = sat(cnt + load_count − 1).
- Greedy selection re-evaluates the tube counts every SELECT, so a restock during dispensing takes effect on the next coin.
- `hrst` mid-operation aborts immediately: `eject_valid` drops, no `done` pulse, counters are cleared.
- `eject_ack` outside EJECT is ignored.

## Timing
- `start` to the first `eject_valid`: 2 cycles (IDLE→SELECT→EJECT).
- Per coin: at least 2 cycles (EJECT with ack in the same cycle, then SELECT).
- Last ack to `done`: 2 cycles (SELECT→DONE).
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Tube count outputs are registered and update on the edge after the ack or load.

## Configuration
- VM2002_CHANGE_TIMEOUT_EN defined:
  - A down-counter loads ACK_TIMEOUT on entry to EJECT and decrements while waiting.
  - If it reaches 0 without an ack, the FSM goes to FAULT with `fault`=1 and `eject_valid`=0.
  - Also on that transition: one `done` pulse, `short_change`=1, `residual`=`remaining`.
  - FAULT exits to IDLE only on `clr_fault`; `start` is ignored while in FAULT.
- Not defined: no counter exists, the FAULT state is unreachable, `fault` is tied to 0, `clr_fault` is unused, and EJECT waits indefinitely.

## Structure
- Add to vm2002_common_pkg:
  - the coin encoding (`change_coin_t`: NONE/NICKEL/DIME/QUARTER);
  - the coin value constants 5/10/25;
  - `chg_state_t`.
- One sub-module, `vm2002_coin_tube`: a single saturating counter with load and decrement ports, instantiated three times.

## Test plan
- Tubes 4Q/4D/4N, `amount`=40, ack returned the cycle after each request → coins Q, D, N; `done` with `residual`=0 and `short_change`=0; tubes end at 3/3/3.
- `quarter_cnt`=0, 2D, 10N, `amount`=50 → coins D, D, N×6; `residual`=0; `dime_cnt`=0, `nickel_cnt`=4.
- 1Q and no other coins, `amount`=37 → one Q, then `done` with `residual`=12 and `short_change`=1.
- `load_valid` to the dime tube with `load_count`=5 on the same cycle as a dime ack, from 2 dimes → `dime_cnt`=6; a load taking the tube to 250+10 saturates at 255.
- With VM2002_CHANGE_TIMEOUT_EN defined and ACK_TIMEOUT=8, ack withheld → `fault`=1 after 8 cycles in EJECT, `done` with `residual`=`amount`; `clr_fault` returns the block to IDLE.
- `hrst` asserted during EJECT → all outputs 0 that cycle (asynchronous); the next `start` proceeds normally.
